// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr} pairs.
// Wrap-around pointers (DEPTH is a power of two) plus an occupancy counter.
// Flush drops every entry but leaves the storage contents alone.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Occupancy update: +1 on push, -1 on pop, both cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // Storage, pointers and counter; reset clears everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= wr_ptr_q + AW'(1);
                end
                if (pop_i)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, combinational imem interface,
// fetch queue towards decode and redirect handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic [31:0]            imem_addr_o,
    input  logic [31:0]            imem_instr_i,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    output logic                   inst_valid_o,
    output logic [31:0]            inst_o,
    output logic [31:0]            inst_pc_o,
    input  logic                   inst_ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count;
    logic          push, pop, has_head;
    fetch_entry_t  wr_entry, head;

    assign has_head     = (count != '0);
    // Redirect masks the head combinationally so decode never sees a stale entry.
    assign inst_valid_o = has_head & ~redirect_i;
    assign pop          = inst_valid_o & inst_ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push         = start_i & ~redirect_i & ((count < CW'(DEPTH)) | pop);

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = imem_instr_i;

    // Next PC: redirect target (word aligned) beats sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i)
            pc_d = redirect_pc_i & ~32'h3;
        else if (push)
            pc_d = pc_q + PC_INC;
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count)
    );

    assign imem_addr_o = pc_q;
    assign inst_o      = head.instr;
    assign inst_pc_o   = head.pc;
    assign count_o     = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change just after the falling edge,
// outputs are checked on the falling edge (half a cycle after the rising edge).
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic [1:0]  count_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    always #5 clk_i = ~clk_i;

    // Combinational instruction memory.
    assign imem_instr_i = imem_addr_o ^ KEY;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i),
        .count_o       (count_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", tag, act, exp);
        end
    endtask

    // Advance one full cycle: rising edge, then back to the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; inst_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        step();
        step();
        rst_i = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
        chk({tag, "_pc"},    inst_pc_o, pc);
        chk({tag, "_instr"}, inst_o, pc ^ KEY);
    endtask

    initial begin
        // Reset state, checked while reset is still held.
        rst_i = 1'b0; start_i = 1'b0; inst_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        @(negedge clk_i);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_count", {30'd0, count_o}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_instr", inst_o, 32'h0);
        chk("rst_ipc",   inst_pc_o, 32'h0);
        rst_i = 1'b1;

        // Streaming: one instruction per cycle, 1 cycle after start.
        start_i = 1'b1; inst_ready_i = 1'b1;
        chk("st_novalid", {31'd0, inst_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_head($sformatf("stream%0d", i), 32'(i * 4));
            chk($sformatf("stream%0d_cnt", i), {30'd0, count_o}, 32'd1);
        end

        // Backpressure from the start: queue fills to 2, PC stops at 8.
        do_reset();
        start_i = 1'b1; inst_ready_i = 1'b0;
        step(); step(); step();
        chk("bp_count", {30'd0, count_o}, 32'd2);
        chk("bp_addr",  imem_addr_o, 32'h8);
        step();
        chk("bp_addr_hold", imem_addr_o, 32'h8);
        chk_head("bp_head", 32'h0);

        // Release ready while full: push+pop together, count stays 2.
        inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_head($sformatf("full%0d", i), 32'(i * 4));
            chk($sformatf("full%0d_cnt", i), {30'd0, count_o}, 32'd2);
            chk($sformatf("full%0d_addr", i), imem_addr_o, 32'(8 + i * 4));
            step();
        end
        // Queue now holds pcs 12 and 16.

        // Redirect with 2 entries queued: valid masked, queue flushed, low bits dropped.
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        #1;
        chk("rd_valid_mask", {31'd0, inst_valid_o}, 32'd0);
        @(negedge clk_i);
        step();
        redirect_i = 1'b0;
        chk("rd_count", {30'd0, count_o}, 32'd0);
        chk("rd_addr",  imem_addr_o, 32'h100);
        chk("rd_valid", {31'd0, inst_valid_o}, 32'd0);
        step();
        chk_head("rd_first", 32'h100);
        step();
        chk_head("rd_second", 32'h104);

        // Redirect to the top of the address space: PC wraps to 0.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        chk_head("wrap_top", 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr_o, 32'h0);
        step();
        chk_head("wrap_zero", 32'h0);

        // Asynchronous reset between edges.
        step();
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_addr",  imem_addr_o, 32'h0);
        chk("arst_count", {30'd0, count_o}, 32'd0);
        chk("arst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("arst_instr", inst_o, 32'h0);
        chk("arst_ipc",   inst_pc_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        chk_head("arst_first", 32'h0);

        // start_i low: PC holds, queue drains.
        start_i = 1'b0;
        step();
        chk("stop_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("stop_addr",  imem_addr_o, 32'h4);
        step();
        chk("stop_addr_hold", imem_addr_o, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a runaway simulation.
    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that sits directly upstream of the single-cycle datapath. It owns the program counter, drives the combinational instruction memory, and buffers fetched instructions in a small queue. It presents them to decode with a valid/ready handshake and supports a redirect (branch/jump) that flushes the queue and reloads the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DEPTH, 2, queue entries; power of two, at least 2
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  fetch enable; no new fetches while low
- imem_addr_o  out  32  fetch address to instruction memory; equals the PC register
- imem_instr_i  in  32  instruction at imem_addr_o, valid the same cycle (combinational memory)
- redirect_i  in  1  flush queue and load PC from redirect_pc_i
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0
- inst_valid_o  out  1  queue head holds a valid instruction
- inst_o  out  32  instruction at queue head
- inst_pc_o  out  32  address of inst_o
- inst_ready_i  in  1  decode accepts head this cycle
- count_o  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- pop = inst_valid_o & inst_ready_i & ~redirect_i.
- push = start_i & ~redirect_i & (count < DEPTH | pop). Push writes {imem_addr_o, imem_instr_i} at the tail, and the PC advances by 4.
- A push and a pop in the same cycle when full are legal. Count is unchanged and the oldest entry leaves.
- redirect_i has priority over everything:
  - Queue is emptied and count goes to 0.
  - PC is loaded with {redirect_pc_i[31:2], 2'b00}.
  - No push and no pop that cycle.
  - inst_valid_o is forced to 0 combinationally during the redirect cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- start_i low: the PC holds and no push happens. Pops continue, so the queue drains.
- Entries are delivered in program order, and none is duplicated or dropped except by redirect.

## Timing
- Reset values:
  - PC and imem_addr_o = RESET_PC.
  - count_o = 0 and inst_valid_o = 0.
  - inst_o = 0 and inst_pc_o = 0.
  - All queue storage is cleared.
- Latency: an instruction pushed in cycle N appears at the head in cycle N+1 if the queue was empty.
- Throughput: 1 instruction per cycle with inst_ready_i held high and start_i high.
- Head outputs are register-driven; only the redirect masking on inst_valid_o is combinational.
- inst_o and inst_pc_o are stable while inst_valid_o=1 and inst_ready_i=0.
- Asserting rst_i low mid-operation returns every register to its reset value immediately, without waiting for a clock. The first fetch after release is at RESET_PC.
- First redirected instruction: pushed in the cycle after the redirect (if start_i is high), visible the cycle after that.

## Structure
- Shared package `fetch_pkg`:
  - RESET_PC default constant.
  - Instruction word width 32 and PC increment 4.
  - typedef `fetch_entry_t` = struct {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`:
  - DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush and count.
  - Wrap-around read/write pointers plus an occupancy counter.
  - Asynchronous active-low reset.
- Top level holds the PC register, the push/pop/redirect logic and the FIFO instance.

## Test plan
- Reset, then start_i=1, inst_ready_i=1, memory returns instr = addr ^ 32'hA5A5_0000.
  - Outputs pc 0, 4, 8, 12 on consecutive cycles starting 1 cycle after start.
- inst_ready_i=0 from the start with DEPTH=2.
  - count_o reaches 2, and imem_addr_o holds at 8 with no further push.
  - After releasing ready, pcs 0, 4, 8 appear in order with no gap or duplicate.
- Queue full while ready=1: push and pop in the same cycle.
  - count_o stays 2 and PC advances by 4 every cycle.
- redirect_i with redirect_pc_i = 32'h0000_0103 while 2 entries are queued.
  - inst_valid_o=0 that cycle and count_o goes to 0.
  - Next delivered inst_pc_o = 32'h0000_0100; the flushed pcs never appear.
- Redirect to 32'hFFFF_FFFC: delivered pcs are FFFF_FFFC then 0000_0000 (wrap).
- rst_i pulsed low mid-stream between clock edges.
  - Outputs reach their reset values asynchronously.
  - After release, the first delivered pc = RESET_PC.
